// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory bus between instruction fetch (IF) and the data
//   load/store path. Data has fixed priority. IF is forced through after
//   MAX_WAIT consecutive data grants while it waits. Only one bus
//   transaction is outstanding at a time. A watchdog aborts a transaction
//   that sees no bus_ack for TIMEOUT cycles and returns an error.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt                      combinational fetch accept
//   if_rvalid/if_rdata/if_err   one-cycle fetch completion
//   d_req/d_addr/d_we/d_size/d_wdata  data request (held until d_gnt)
//   d_gnt                       combinational data accept
//   d_rvalid/d_rdata/d_err      one-cycle data completion (loads and stores)
//   bus_req/bus_addr/bus_we/bus_size/bus_wdata  registered bus request
//   bus_ack/bus_rdata           bus completion and read data
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no transaction; arbitrate and grant this cycle
// BUSY_IF | fetch on the bus, waiting for ack or timeout
// BUSY_D  | data access on the bus, waiting for ack or timeout

module mem_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [2:0]  bus_size,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timeout_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            starved;
    logic            timed_out;
    logic            busy;
    logic [31:0]     resp_data;

    assign starved   = (starve_cnt == SW'(MAX_WAIT));
    assign timed_out = (timeout_cnt == TW'(TIMEOUT - 1));
    assign busy      = (state == BUSY_IF) || (state == BUSY_D);
    // Stores return zero data regardless of what the bus drives.
    assign resp_data = bus_we ? 32'd0 : bus_rdata;

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (d_req && !(if_req && starved)) begin
                        d_gnt     = 1'b1;
                        state_nxt = BUSY_D;
                    end else if (if_req) begin
                        if_gnt    = 1'b1;
                        state_nxt = BUSY_IF;
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                // ack takes precedence over the watchdog in the same cycle
                if (bus_ack || timed_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            timeout_cnt <= '0;
            bus_req     <= 1'b0;
            bus_addr    <= 32'd0;
            bus_we      <= 1'b0;
            bus_size    <= 3'd0;
            bus_wdata   <= 32'd0;
            if_rvalid   <= 1'b0;
            if_rdata    <= 32'd0;
            if_err      <= 1'b0;
            d_rvalid    <= 1'b0;
            d_rdata     <= 32'd0;
            d_err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'd0;
            d_err     <= 1'b0;

            if (d_gnt) begin
                bus_req     <= 1'b1;
                bus_addr    <= d_addr;
                bus_we      <= d_we;
                bus_size    <= d_size;
                bus_wdata   <= d_wdata;
                timeout_cnt <= '0;
                if (if_req && !starved) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else if (if_gnt) begin
                bus_req     <= 1'b1;
                bus_addr    <= if_addr;
                bus_we      <= 1'b0;
                bus_size    <= 3'b010;
                bus_wdata   <= 32'd0;
                timeout_cnt <= '0;
                starve_cnt  <= '0;
            end

            if (busy) begin
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    if (state == BUSY_IF) begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= resp_data;
                    end else begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= resp_data;
                    end
                end else if (timed_out) begin
                    bus_req <= 1'b0;
                    if (state == BUSY_IF) begin
                        if_rvalid <= 1'b1;
                        if_err    <= 1'b1;
                    end else begin
                        d_rvalid <= 1'b1;
                        d_err    <= 1'b1;
                    end
                end else begin
                    timeout_cnt <= timeout_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1ns after the rising
// edge; outputs (including the combinational grants) are checked on the
// falling edge of the same cycle.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [2:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(4), .TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_size  (bus_size),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance to the drive point of the next cycle
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        bus_ack = 1'b0;
        repeat (n) next_cyc();
        reset = 1'b0;
    endtask

    initial begin
        int n_busy;
        int n_gnt;
        logic [7:0] order [10];
        logic [7:0] exp_order [10];
        exp_order = '{"D","D","D","D","I","D","D","D","D","I"};

        reset = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_addr = 32'd0; d_we = 1'b0; d_size = 3'd0; d_wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;

        // 1: reset held with both requesting
        #1;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
            check("rst_bus_req", {31'd0, bus_req}, 32'd0);
            next_cyc();
        end
        reset = 1'b0;
        sample();
        check("post_rst_d_gnt", {31'd0, d_gnt}, 32'd1);
        check("post_rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("post_rst_rvalid", {31'd0, d_rvalid}, 32'd0);

        // 2: IF only, ack two cycles after bus_req rises
        do_reset(2);
        if_req = 1'b1; if_addr = 32'h100;
        sample();
        check("if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cyc();
        if_req = 1'b0;
        sample();
        check("if_bus_req", {31'd0, bus_req}, 32'd1);
        check("if_bus_addr", bus_addr, 32'h100);
        check("if_bus_size", {29'd0, bus_size}, 32'd2);
        check("if_bus_we", {31'd0, bus_we}, 32'd0);
        next_cyc();
        sample();
        check("if_bus_req_hold", {31'd0, bus_req}, 32'd1);
        next_cyc();
        bus_ack = 1'b1; bus_rdata = 32'h00500093;
        sample();
        check("if_rvalid_early", {31'd0, if_rvalid}, 32'd0);
        next_cyc();
        bus_ack = 1'b0; bus_rdata = 32'd0;
        sample();
        check("if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("if_rdata", if_rdata, 32'h00500093);
        check("if_err", {31'd0, if_err}, 32'd0);
        check("if_bus_req_drop", {31'd0, bus_req}, 32'd0);
        next_cyc();
        sample();
        check("if_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);
        check("if_rdata_clear", if_rdata, 32'd0);

        // 3: both requesting, immediate acks -> starvation bound
        do_reset(2);
        if_req = 1'b1; d_req = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1234;
        n_gnt = 0;
        for (int c = 0; c < 60 && n_gnt < 10; c++) begin
            sample();
            if (if_gnt && d_gnt) check("both_gnt", 32'd1, 32'd0);
            if (d_gnt) begin order[n_gnt] = "D"; n_gnt++; end
            else if (if_gnt) begin order[n_gnt] = "I"; n_gnt++; end
            next_cyc();
        end
        check("order_count", n_gnt, 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < n_gnt) check($sformatf("order_%0d", i), {24'd0, order[i]}, {24'd0, exp_order[i]});
        end

        // 4: byte store
        do_reset(2);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1003; d_size = 3'b000; d_wdata = 32'hAB;
        sample();
        check("st_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        d_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        sample();
        check("st_bus_we", {31'd0, bus_we}, 32'd1);
        check("st_bus_size", {29'd0, bus_size}, 32'd0);
        check("st_bus_wdata", bus_wdata, 32'hAB);
        check("st_bus_addr", bus_addr, 32'h1003);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        check("st_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("st_d_rdata", d_rdata, 32'd0);
        check("st_d_err", {31'd0, d_err}, 32'd0);

        // 5: load with no ack -> watchdog
        do_reset(2);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_size = 3'b010; d_wdata = 32'd0;
        sample();
        check("to_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        d_req = 1'b0;
        n_busy = 0;
        for (int c = 0; c < 400; c++) begin
            sample();
            if (!bus_req) break;
            if (d_rvalid) check("to_rvalid_early", 32'd1, 32'd0);
            n_busy++;
            next_cyc();
        end
        check("to_busy_cycles", n_busy, 32'd255);
        check("to_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("to_d_err", {31'd0, d_err}, 32'd1);
        check("to_d_rdata", d_rdata, 32'd0);
        next_cyc();
        bus_ack = 1'b1; bus_rdata = 32'h55;
        sample();
        check("late_ack_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("late_ack_err", {31'd0, d_err}, 32'd0);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        check("late_ack_ignored", {31'd0, d_rvalid}, 32'd0);
        check("late_ack_bus_req", {31'd0, bus_req}, 32'd0);
        next_cyc();
        d_req = 1'b1; d_addr = 32'h3000;
        sample();
        check("after_to_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        d_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
        sample();
        check("after_to_bus_addr", bus_addr, 32'h3000);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        check("after_to_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("after_to_rdata", d_rdata, 32'h12345678);
        check("after_to_err", {31'd0, d_err}, 32'd0);

        // 6: reset during BUSY_D
        do_reset(2);
        d_req = 1'b1; d_addr = 32'h4000; d_we = 1'b0;
        sample();
        check("mr_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        d_req = 1'b0;
        sample();
        check("mr_bus_req", {31'd0, bus_req}, 32'd1);
        next_cyc();
        reset = 1'b1;
        sample();
        next_cyc();
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h400;
        sample();
        check("mr_bus_req_drop", {31'd0, bus_req}, 32'd0);
        check("mr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("mr_if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cyc();
        if_req = 1'b0;
        sample();
        check("mr_no_rvalid2", {31'd0, d_rvalid}, 32'd0);
        check("mr_if_bus_req", {31'd0, bus_req}, 32'd1);
        check("mr_if_bus_addr", bus_addr, 32'h400);
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
